k10_axil_bridge: RTL and testbench
==================================

Name: k10_axil_bridge

Overview:
- Upstream bus master feeding the K10 peripheral fabric: converts the core's single-outstanding data-port requests (req/gnt/rvalid) into AXI4-Lite master transactions.
- Typical targets are the simulation controller (CHAR_OUT, SIM_CTRL, MSIP, cycle count) and other AXI4-Lite slaves.
- One transaction in flight at a time.
- A response timeout guarantees the core never hangs on an unresponsive slave.

Parameters:
- TIMEOUT_CYCLES, 1024: response-wait cycles before an error is returned to the core; 0 disables the timeout.
- AXI_PROT, 3'b000: constant value driven on m_axi_awprot and m_axi_arprot.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req  input  1  core request valid.
- i_we  input  1  1 = write, 0 = read.
- i_addr  input  32  byte address.
- i_wdata  input  32  write data.
- i_be  input  4  byte enables.
- o_gnt  output  1  request accepted this cycle.
- o_rvalid  output  1  one-cycle response pulse.
- o_rdata  output  32  read data, valid with o_rvalid.
- o_err  output  1  error flag, valid with o_rvalid.
- m_axi_awaddr  output  32; m_axi_awprot  output  3; m_axi_awvalid  output  1; m_axi_awready  input  1.
- m_axi_wdata  output  32; m_axi_wstrb  output  4; m_axi_wvalid  output  1; m_axi_wready  input  1.
- m_axi_bresp  input  2; m_axi_bvalid  input  1; m_axi_bready  output  1.
- m_axi_araddr  output  32; m_axi_arprot  output  3; m_axi_arvalid  output  1; m_axi_arready  input  1.
- m_axi_rdata  input  32; m_axi_rresp  input  2; m_axi_rvalid  input  1; m_axi_rready  output  1.

Behaviour:
- Reset: state IDLE. All valids/readies, o_gnt, o_rvalid and o_err are 0; o_rdata is 0; captured address, data and strobes are 0.
- Reset mid-transaction: immediate abort to IDLE with all outputs at reset values; no response is issued to the core.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_RESP, DRAIN.
- IDLE:
  - o_gnt = i_req (combinational); o_gnt is 0 in every other state.
  - On i_req & o_gnt: register i_addr, i_wdata, i_be and i_we.
  - Next state WR_ADDR_DATA if i_we, else RD_ADDR.
- WR_ADDR_DATA:
  - awvalid and wvalid are both registered-high from the cycle after grant.
  - AW and W complete independently; each valid drops the cycle after its own handshake (tracked by aw_done/w_done flags).
  - Valids are never withdrawn before their handshake.
  - Address, data and strobe outputs hold stable while their valid is high.
  - When both handshakes are complete (same or different cycles), go to WR_RESP.
- WR_RESP:
  - m_axi_bready = 1.
  - On bvalid: o_rvalid pulses on the next cycle with o_err = bresp[1] and o_rdata = 0; return to IDLE.
- RD_ADDR: arvalid high until arready, then RD_RESP.
- RD_RESP:
  - m_axi_rready = 1.
  - On rvalid: the next cycle pulses o_rvalid with o_rdata = rdata and o_err = rresp[1]; return to IDLE.
- Response latency: grant in cycle N; AXI valids first high in N+1. With zero-wait slave handshakes in N+1 and the response in N+2, o_rvalid is high in N+3.
- o_rvalid is exactly one cycle. o_rdata and o_err hold their values until the next o_rvalid.
- Timeout:
  - A 32-bit counter clears on entry to WR_RESP or RD_RESP and increments each cycle in those states.
  - If it reaches TIMEOUT_CYCLES (nonzero) without a response: o_rvalid pulses next cycle with o_err = 1 and o_rdata = 0, and the FSM goes to DRAIN.
  - A response arriving in the same cycle as the counter reaching the limit wins: normal response, no timeout.
  - The timeout does not apply during address/data phases, since AXI valids cannot be withdrawn.
- DRAIN: bready (if write) or rready (if read) stays high. The late response is discarded with no core pulse; then return to IDLE. o_gnt is 0 throughout DRAIN.
- SLVERR (2'b10) and DECERR (2'b11) both set o_err; OKAY and EXOKAY do not.
- A new request can be granted in the same cycle o_rvalid is high (IDLE entered that cycle).

Test Plan:
- Write 0x41 to addr 0x04, be 4'hF, slave always ready → awvalid/wvalid in N+1, bresp OKAY in N+2, o_rvalid in N+3 with o_err = 0; slave prints 'A'.
- Read addr 0x0C from a slave that returns 0x0000_1234 → o_rdata = 0x0000_1234, o_err = 0, one-cycle o_rvalid.
- Slave delays awready 3 cycles after wready → wvalid drops after 1 cycle; awaddr held stable; single o_rvalid after bvalid.
- TIMEOUT_CYCLES = 8, slave never asserts bvalid → o_rvalid with o_err = 1 at 8 cycles after entering WR_RESP. A bvalid 20 cycles later is swallowed with no pulse; gnt resumes afterwards.
- Read returns rresp = 2'b10 → o_err = 1 with o_rdata = rdata.
- Assert i_rst while arvalid is pending → all outputs 0 in the same cycle; after release, a fresh read completes normally.

Source files
------------

// File: rtl/k10_axil_bridge.sv
// ---------------------------------------------------------------------------
// k10_axil_bridge
// Turns the core's single-outstanding data-port protocol (req/gnt/rvalid)
// into AXI4-Lite master transactions. Only one transaction is in flight at a
// time. A response timeout keeps the core from hanging on a silent slave.
//
// Ports
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_req/i_we/i_addr/   core request: valid, write flag, byte address,
//   i_wdata/i_be         write data, byte enables
//   o_gnt                request accepted (combinational, IDLE only)
//   o_rvalid/o_rdata/    one-cycle response pulse, read data, error flag;
//   o_err                data and error hold until the next pulse
//   m_axi_aw*/w*/b*      AXI4-Lite write address, write data, write response
//   m_axi_ar*/r*         AXI4-Lite read address, read data
// ---------------------------------------------------------------------------
module k10_axil_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [2:0]  AXI_PROT       = 3'b000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic        o_gnt,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WR_ADDR_DATA = 3'd1,
        S_WR_RESP      = 3'd2,
        S_RD_ADDR      = 3'd3,
        S_RD_RESP      = 3'd4,
        S_DRAIN        = 3'd5
    } state_t;

    // The timeout fires in the cycle whose increment would bring the wait
    // counter to TIMEOUT_CYCLES, i.e. after TIMEOUT_CYCLES cycles of waiting.
    localparam logic [31:0] C_TO_LIMIT = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      r_state, w_state;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic [3:0]  r_be, w_be;
    logic        r_we, w_we;
    logic        r_awvalid, w_awvalid;
    logic        r_wvalid, w_wvalid;
    logic        r_aw_done, w_aw_done;
    logic        r_w_done, w_w_done;
    logic        r_arvalid, w_arvalid;
    logic        r_bready, w_bready;
    logic        r_rready, w_rready;
    logic        r_rvalid, w_rvalid;
    logic [31:0] r_rdata, w_rdata;
    logic        r_err, w_err;
    logic [31:0] r_cnt, w_cnt;
    logic        w_gnt;
    logic        w_timeout;
    logic        w_berr;
    logic        w_rerr;

    // SLVERR (10) and DECERR (11) are errors; OKAY and EXOKAY are not.
    assign w_berr    = (m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11);
    assign w_rerr    = (m_axi_rresp == 2'b10) || (m_axi_rresp == 2'b11);
    assign w_timeout = (TIMEOUT_CYCLES != 32'd0) && (r_cnt == C_TO_LIMIT);

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        w_state   = r_state;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_be      = r_be;
        w_we      = r_we;
        w_awvalid = r_awvalid;
        w_wvalid  = r_wvalid;
        w_aw_done = r_aw_done;
        w_w_done  = r_w_done;
        w_arvalid = r_arvalid;
        w_rvalid  = 1'b0;
        w_rdata   = r_rdata;
        w_err     = r_err;
        w_cnt     = r_cnt;
        w_gnt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt = i_req;
                if (i_req) begin
                    w_addr  = i_addr;
                    w_wdata = i_wdata;
                    w_be    = i_be;
                    w_we    = i_we;
                    if (i_we) begin
                        w_state   = S_WR_ADDR_DATA;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                        w_aw_done = 1'b0;
                        w_w_done  = 1'b0;
                    end else begin
                        w_state   = S_RD_ADDR;
                        w_arvalid = 1'b1;
                    end
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_WR_ADDR_DATA: begin
                // AW and W channels complete independently of each other.
                if (r_awvalid && m_axi_awready) begin
                    w_awvalid = 1'b0;
                    w_aw_done = 1'b1;
                end else begin
                    w_awvalid = r_awvalid;
                end
                if (r_wvalid && m_axi_wready) begin
                    w_wvalid = 1'b0;
                    w_w_done = 1'b1;
                end else begin
                    w_wvalid = r_wvalid;
                end
                if (w_aw_done && w_w_done) begin
                    w_state = S_WR_RESP;
                    w_cnt   = 32'd0;
                end else begin
                    w_state = S_WR_ADDR_DATA;
                end
            end
            S_WR_RESP: begin
                // A response in the same cycle as the limit wins over timeout.
                if (m_axi_bvalid) begin
                    w_rvalid = 1'b1;
                    w_err    = w_berr;
                    w_rdata  = 32'd0;
                    w_state  = S_IDLE;
                end else if (w_timeout) begin
                    w_rvalid = 1'b1;
                    w_err    = 1'b1;
                    w_rdata  = 32'd0;
                    w_state  = S_DRAIN;
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    w_arvalid = 1'b0;
                    w_state   = S_RD_RESP;
                    w_cnt     = 32'd0;
                end else begin
                    w_state = S_RD_ADDR;
                end
            end
            S_RD_RESP: begin
                if (m_axi_rvalid) begin
                    w_rvalid = 1'b1;
                    w_err    = w_rerr;
                    w_rdata  = m_axi_rdata;
                    w_state  = S_IDLE;
                end else if (w_timeout) begin
                    w_rvalid = 1'b1;
                    w_err    = 1'b1;
                    w_rdata  = 32'd0;
                    w_state  = S_DRAIN;
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end
            S_DRAIN: begin
                // The late response is swallowed without a core pulse.
                if (r_we ? m_axi_bvalid : m_axi_rvalid) begin
                    w_state = S_IDLE;
                end else begin
                    w_state = S_DRAIN;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        // Response readies are registered from the state being entered.
        w_bready = (w_state == S_WR_RESP) || ((w_state == S_DRAIN) && w_we);
        w_rready = (w_state == S_RD_RESP) || ((w_state == S_DRAIN) && !w_we);
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_we      <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_err     <= 1'b0;
            r_cnt     <= 32'd0;
        end else begin
            r_state   <= w_state;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_be      <= w_be;
            r_we      <= w_we;
            r_awvalid <= w_awvalid;
            r_wvalid  <= w_wvalid;
            r_aw_done <= w_aw_done;
            r_w_done  <= w_w_done;
            r_arvalid <= w_arvalid;
            r_bready  <= w_bready;
            r_rready  <= w_rready;
            r_rvalid  <= w_rvalid;
            r_rdata   <= w_rdata;
            r_err     <= w_err;
            r_cnt     <= w_cnt;
        end
    end

    // Grant is masked during reset so every output reads as reset value.
    assign o_gnt         = w_gnt && !i_rst;
    assign o_rvalid      = r_rvalid;
    assign o_rdata       = r_rdata;
    assign o_err         = r_err;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = AXI_PROT;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_be;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = AXI_PROT;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_k10_axil_bridge.sv
// ---------------------------------------------------------------------------
// tb_k10_axil_bridge
// Directed bench for k10_axil_bridge. Inputs are driven and registered
// outputs sampled on the falling edge; o_gnt is sampled #1 after inputs
// change. The slave side is played cycle by cycle inside each scenario task.
// ---------------------------------------------------------------------------
module tb_k10_axil_bridge;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_be;
    logic        o_gnt;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    k10_axil_bridge #(
        .TIMEOUT_CYCLES(8),
        .AXI_PROT      (3'b000)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_be         (i_be),
        .o_gnt        (o_gnt),
        .o_rvalid     (o_rvalid),
        .o_rdata      (o_rdata),
        .o_err        (o_err),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awprot (m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    task automatic test_reset;
        i_rst = 1'b1; i_req = 1'b1; i_we = 1'b1;
        i_addr = 32'hFFFF_FFFF; i_wdata = 32'hFFFF_FFFF; i_be = 4'hF;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_gnt, o_rvalid, o_err, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             m_axi_arvalid, m_axi_rready} !== 8'h00) begin
            errors++;
            $display("FAIL rst_ctrl got %b exp 00000000", {o_gnt, o_rvalid, o_err,
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        checks++;
        if ({o_rdata, m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr} !== 132'd0) begin
            errors++;
            $display("FAIL rst_data got %h %h %h %h %h exp all zero", o_rdata, m_axi_awaddr,
                     m_axi_wdata, m_axi_wstrb, m_axi_araddr);
        end
        checks++;
        if ({m_axi_awprot, m_axi_arprot} !== 6'b000000) begin
            errors++;
            $display("FAIL rst_prot got %b exp 000000", {m_axi_awprot, m_axi_arprot});
        end
        i_rst = 1'b0; i_req = 1'b0; i_we = 1'b0;
        i_addr = 32'd0; i_wdata = 32'd0; i_be = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_write;
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0000_0004; i_wdata = 32'h0000_0041; i_be = 4'hF;
        #1;
        checks++;
        if (o_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", o_gnt); end
        @(negedge clk);  // N+1
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb}
            !== {1'b1, 1'b1, 32'h0000_0004, 32'h0000_0041, 4'hF}) begin
            errors++;
            $display("FAIL wr_aw_w got %b %b %h %h %h exp 1 1 00000004 00000041 f", m_axi_awvalid,
                     m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
        end
        checks++;
        if (o_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt_busy got %b exp 0", o_gnt); end
        i_req = 1'b0;
        @(negedge clk);  // N+2
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_rvalid} !== 4'b0010) begin
            errors++;
            $display("FAIL wr_bphase got %b exp 0010", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_rvalid});
        end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        @(negedge clk);  // N+3
        checks++;
        if ({o_rvalid, o_err, o_rdata, m_axi_bready} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL wr_resp got %b %b %h %b exp 1 0 00000000 0", o_rvalid, o_err, o_rdata, m_axi_bready);
        end
        m_axi_bvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_rvalid !== 1'b0) begin errors++; $display("FAIL wr_pulse_len got %b exp 0", o_rvalid); end
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [31:0] rd,
                            input logic [1:0] rr, input logic exp_err, input string tag);
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = addr;
        #1;
        checks++;
        if (o_gnt !== 1'b1) begin errors++; $display("FAIL %s_gnt got %b exp 1", tag, o_gnt); end
        @(negedge clk);
        checks++;
        if ({m_axi_arvalid, m_axi_araddr, m_axi_arprot} !== {1'b1, addr, 3'b000}) begin
            errors++;
            $display("FAIL %s_ar got %b %h %b exp 1 %h 000", tag, m_axi_arvalid, m_axi_araddr, m_axi_arprot, addr);
        end
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_axi_arvalid, m_axi_rready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_rphase got %b exp 01", tag, {m_axi_arvalid, m_axi_rready});
        end
        m_axi_rvalid = 1'b1; m_axi_rdata = rd; m_axi_rresp = rr;
        @(negedge clk);
        checks++;
        if ({o_rvalid, o_err, o_rdata, m_axi_rready} !== {1'b1, exp_err, rd, 1'b0}) begin
            errors++;
            $display("FAIL %s_resp got %b %b %h %b exp 1 %b %h 0", tag, o_rvalid, o_err, o_rdata,
                     m_axi_rready, exp_err, rd);
        end
        m_axi_rvalid = 1'b0; m_axi_rdata = 32'hBAD0_BAD0; m_axi_rresp = 2'b00;
        @(negedge clk);
        checks++;
        if ({o_rvalid, o_rdata, o_err} !== {1'b0, rd, exp_err}) begin
            errors++;
            $display("FAIL %s_hold got %b %h %b exp 0 %h %b", tag, o_rvalid, o_rdata, o_err, rd, exp_err);
        end
    endtask

    task automatic test_read;
        read_txn(32'h0000_000C, 32'h0000_1234, 2'b00, 1'b0, "rd_okay");
        read_txn(32'h0000_0014, 32'hFFFF_0000, 2'b01, 1'b0, "rd_exokay");
        read_txn(32'h0000_0018, 32'h0BAD_F00D, 2'b11, 1'b1, "rd_decerr");
    endtask

    task automatic test_aw_delay;
        m_axi_awready = 1'b0; m_axi_wready = 1'b1;
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0000_0008; i_wdata = 32'hDEAD_BEEF; i_be = 4'h3;
        #1;
        checks++;
        if (o_gnt !== 1'b1) begin errors++; $display("FAIL awd_gnt got %b exp 1", o_gnt); end
        @(negedge clk);  // N+1: both valids up, only W handshakes
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin
            errors++; $display("FAIL awd_valids got %b exp 11", {m_axi_awvalid, m_axi_wvalid});
        end
        i_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);  // N+2..N+4: AW still waiting
            checks++;
            if ({m_axi_wvalid, m_axi_awvalid, m_axi_awaddr, m_axi_bready, o_rvalid}
                !== {1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL awd_wait%0d got %b %b %h %b %b exp 0 1 00000008 0 0", k, m_axi_wvalid,
                         m_axi_awvalid, m_axi_awaddr, m_axi_bready, o_rvalid);
            end
        end
        m_axi_awready = 1'b1;
        @(negedge clk);  // N+5
        checks++;
        if ({m_axi_awvalid, m_axi_bready, o_rvalid} !== 3'b010) begin
            errors++; $display("FAIL awd_bphase got %b exp 010", {m_axi_awvalid, m_axi_bready, o_rvalid});
        end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b01;
        @(negedge clk);  // N+6
        checks++;
        if ({o_rvalid, o_err, o_rdata} !== {1'b1, 1'b0, 32'd0}) begin
            errors++; $display("FAIL awd_resp got %b %b %h exp 1 0 00000000", o_rvalid, o_err, o_rdata);
        end
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        @(negedge clk);
        checks++;
        if (o_rvalid !== 1'b0) begin errors++; $display("FAIL awd_single got %b exp 0", o_rvalid); end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0000_0004; i_wdata = 32'h0000_0042; i_be = 4'hF;
        #1;
        checks++;
        if (o_gnt !== 1'b1) begin errors++; $display("FAIL to_gnt got %b exp 1", o_gnt); end
        @(negedge clk);  // N+1 handshakes
        i_req = 1'b0;
        @(negedge clk);  // first WR_RESP cycle
        checks++;
        if ({m_axi_bready, o_rvalid} !== 2'b10) begin
            errors++; $display("FAIL to_entry got %b exp 10", {m_axi_bready, o_rvalid});
        end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (o_rvalid !== 1'b0) begin errors++; $display("FAIL to_early%0d got %b exp 0", k, o_rvalid); end
        end
        @(negedge clk);  // 8 cycles after entering WR_RESP
        checks++;
        if ({o_rvalid, o_err, o_rdata, m_axi_bready} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL to_resp got %b %b %h %b exp 1 1 00000000 1", o_rvalid, o_err, o_rdata, m_axi_bready);
        end
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_000C;
        #1;
        checks++;
        if (o_gnt !== 1'b0) begin errors++; $display("FAIL to_gnt_drain got %b exp 0", o_gnt); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({o_gnt, o_rvalid, m_axi_bready} !== 3'b001) begin
                errors++; $display("FAIL to_drain%0d got %b exp 001", k, {o_gnt, o_rvalid, m_axi_bready});
            end
        end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        @(negedge clk);  // late response swallowed, back in IDLE
        checks++;
        if ({o_rvalid, m_axi_bready, o_gnt} !== 3'b001) begin
            errors++; $display("FAIL to_swallow got %b exp 001", {o_rvalid, m_axi_bready, o_gnt});
        end
        m_axi_bvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 32'h0000_000C}) begin
            errors++; $display("FAIL to_resume_ar got %b %h exp 1 0000000c", m_axi_arvalid, m_axi_araddr);
        end
        i_req = 1'b0;
        @(negedge clk);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_55AA; m_axi_rresp = 2'b00;
        @(negedge clk);
        checks++;
        if ({o_rvalid, o_err, o_rdata} !== {1'b1, 1'b0, 32'h0000_55AA}) begin
            errors++; $display("FAIL to_resume_resp got %b %b %h exp 1 0 000055aa", o_rvalid, o_err, o_rdata);
        end
        m_axi_rvalid = 1'b0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0010;
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hCAFE_0001; m_axi_rresp = 2'b10;
        @(negedge clk);
        checks++;
        if ({o_rvalid, o_err, o_rdata} !== {1'b1, 1'b1, 32'hCAFE_0001}) begin
            errors++; $display("FAIL b2b_slverr got %b %b %h exp 1 1 cafe0001", o_rvalid, o_err, o_rdata);
        end
        m_axi_rvalid = 1'b0;
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0000_0020; i_wdata = 32'h0000_0011; i_be = 4'h1;
        #1;
        checks++;
        if (o_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt got %b exp 1", o_gnt); end
        @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_wstrb, o_rvalid} !== {1'b1, 1'b1, 4'h1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_aw got %b %b %h %b exp 1 1 1 0", m_axi_awvalid, m_axi_wvalid, m_axi_wstrb, o_rvalid);
        end
        i_req = 1'b0;
        @(negedge clk);
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b11;
        @(negedge clk);
        checks++;
        if ({o_rvalid, o_err, o_rdata} !== {1'b1, 1'b1, 32'd0}) begin
            errors++; $display("FAIL b2b_decerr got %b %b %h exp 1 1 00000000", o_rvalid, o_err, o_rdata);
        end
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    endtask

    task automatic test_reset_mid;
        m_axi_arready = 1'b0;
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0030;
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 32'h0000_0030}) begin
            errors++; $display("FAIL rm_pending got %b %h exp 1 00000030", m_axi_arvalid, m_axi_araddr);
        end
        i_rst = 1'b1; i_req = 1'b1;
        #1;
        checks++;
        if ({o_gnt, m_axi_arvalid, m_axi_rready, o_rvalid, o_err, o_rdata, m_axi_araddr}
            !== {5'b00000, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL rm_abort got %b %b %b %b %b %h %h exp all zero", o_gnt, m_axi_arvalid,
                     m_axi_rready, o_rvalid, o_err, o_rdata, m_axi_araddr);
        end
        @(negedge clk);
        checks++;
        if ({o_rvalid, m_axi_arvalid} !== 2'b00) begin
            errors++; $display("FAIL rm_held got %b exp 00", {o_rvalid, m_axi_arvalid});
        end
        i_rst = 1'b0; i_req = 1'b0; m_axi_arready = 1'b1;
        read_txn(32'h0000_000C, 32'h0000_00AB, 2'b00, 1'b0, "rm_fresh");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_aw_delay();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
